// File: rtl/i2c_pkg.sv
// Shared types for the two-master I2C bridge arbiter: FSM encoding, per-port
// bus event bundle and the master-port count.
package i2c_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [2:0] {
    IDLE,
    REPLAY_SDA,
    REPLAY_SCL,
    GRANT,
    FREE
  } arb_state_e;

  typedef struct packed {
    logic start;
    logic stop;
    logic scl_edge;
  } bus_evt_t;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises one upstream master port's SCL/SDA and reports START, STOP and
// SCL edges; events appear three clocks after the pin changes.
module i2c_bus_monitor
  import i2c_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     scl_in,
  input  logic     sda_in,
  output logic     scl_sync,
  output bus_evt_t evt
);

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  // p0/p1: metastability synchroniser, p2: previous level for edge detection.
  // Flops reset to the idle-high bus level so reset release never fakes an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_in;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda_in;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_sync     = scl_p1;
  assign evt.start    = sda_p2 & ~sda_p1 & scl_p1 & scl_p2;
  assign evt.stop     = ~sda_p2 & sda_p1 & scl_p1 & scl_p2;
  assign evt.scl_edge = scl_p1 ^ scl_p2;

endmodule

// File: rtl/i2c_bridge_arbiter.sv
// Grants one shared downstream I2C segment to one of two upstream masters per
// transaction, stretching the loser's SCL and replaying its START downstream.
module i2c_bridge_arbiter
  import i2c_pkg::*;
#(
  parameter int BUS_FREE_CYCLES   = 16,
  parameter int START_HOLD_CYCLES = 16,
  parameter int TIMEOUT_CYCLES    = 65535,
  parameter int CNT_W             = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_m0_in,
  input  logic       sda_m0_in,
  input  logic       scl_m1_in,
  input  logic       sda_m1_in,
  output logic [1:0] bridge_en,
  output logic [1:0] scl_hold,
  output logic       scl_dn_low,
  output logic       sda_dn_low,
  output logic       owner,
  output logic       busy,
  output logic       timeout
);

  // Counters load N-1 and leave their state on the cycle they read 0,
  // so each phase lasts exactly N clocks.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(START_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] FREE_LOAD = CNT_W'(BUS_FREE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [NUM_MASTERS-1:0] scl_sync;
  bus_evt_t               evt [NUM_MASTERS];

  arb_state_e             state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [NUM_MASTERS-1:0] pend, pend_nxt;
  logic                   owner_nxt;
  logic                   timeout_nxt;

  i2c_bus_monitor u_mon0 (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_m0_in),
    .sda_in   (sda_m0_in),
    .scl_sync (scl_sync[0]),
    .evt      (evt[0])
  );

  i2c_bus_monitor u_mon1 (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_m1_in),
    .sda_in   (sda_m1_in),
    .scl_sync (scl_sync[1]),
    .evt      (evt[1])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pend    <= '0;
      owner   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      owner   <= owner_nxt;
      timeout <= timeout_nxt;
    end
  end

  always_ff @(posedge clk) begin
    cnt <= cnt_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    owner_nxt   = owner;
    timeout_nxt = 1'b0;
    // A START from the active owner is a repeated START and passes through.
    for (int n = 0; n < NUM_MASTERS; n++) begin
      pend_nxt[n] = pend[n] | (evt[n].start & ~(state == GRANT && owner == 1'(n)));
    end

    case (state)
      IDLE: begin
        if (|pend) begin
          owner_nxt = (&pend) ? ~owner : pend[1];
          cnt_nxt   = HOLD_LOAD;
          state_nxt = REPLAY_SDA;
        end
      end
      REPLAY_SDA: begin
        if (cnt == '0) begin
          cnt_nxt   = HOLD_LOAD;
          state_nxt = REPLAY_SCL;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      REPLAY_SCL: begin
        if (cnt == '0) begin
          cnt_nxt   = TO_LOAD;
          state_nxt = GRANT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GRANT: begin
        pend_nxt[owner] = 1'b0;
        if (evt[owner].stop) begin
          cnt_nxt   = FREE_LOAD;
          state_nxt = FREE;
        end else if (evt[owner].scl_edge) begin
          cnt_nxt = TO_LOAD;
        end else if (cnt == '0) begin
          cnt_nxt     = FREE_LOAD;
          state_nxt   = FREE;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      FREE: begin
        if (evt[owner].start) begin
          cnt_nxt = FREE_LOAD;
        end else if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Drives are decoded from registered state so every release lands on the
  // same cycle as the state change that causes it.
  always_comb begin
    bridge_en = '0;
    if (state == GRANT) bridge_en[owner] = 1'b1;
    for (int n = 0; n < NUM_MASTERS; n++) begin
      scl_hold[n] = pend[n] & ~scl_sync[n] & ~(state == GRANT && owner == 1'(n));
    end
  end

  assign sda_dn_low = (state == REPLAY_SDA) || (state == REPLAY_SCL);
  assign scl_dn_low = (state == REPLAY_SCL);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_i2c_bridge_arbiter.sv
// Scenario bench for i2c_bridge_arbiter: drives both upstream ports as simple
// I2C masters and scoreboards the order of downstream grants.
module tb_i2c_bridge_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl0, sda0, scl1, sda1;
  logic [1:0] bridge_en, scl_hold;
  logic       scl_dn_low, sda_dn_low, owner, busy, timeout;

  int   errors = 0;
  int   checks = 0;
  logic exp_q[$];
  logic sb_exp;
  logic [1:0] sb_want;
  logic [1:0] prev_en = 2'b00;

  always #5 clk = ~clk;

  i2c_bridge_arbiter #(
    .BUS_FREE_CYCLES   (16),
    .START_HOLD_CYCLES (16),
    .TIMEOUT_CYCLES    (100),
    .CNT_W             (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scl_m0_in  (scl0),
    .sda_m0_in  (sda0),
    .scl_m1_in  (scl1),
    .sda_m1_in  (sda1),
    .bridge_en  (bridge_en),
    .scl_hold   (scl_hold),
    .scl_dn_low (scl_dn_low),
    .sda_dn_low (sda_dn_low),
    .owner      (owner),
    .busy       (busy),
    .timeout    (timeout)
  );

  // Scoreboard: every new grant is popped against the queued expected owner.
  always @(negedge clk) begin
    if (reset) begin
      prev_en = 2'b00;
    end else begin
      if (bridge_en != 2'b00 && prev_en == 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL grant_order: unexpected grant bridge_en=%b, none queued", bridge_en);
        end else begin
          sb_exp  = exp_q.pop_front();
          sb_want = sb_exp ? 2'b10 : 2'b01;
          if (bridge_en !== sb_want || owner !== sb_exp) begin
            errors++;
            $display("FAIL grant_order: bridge_en=%b owner=%b, required %b owner=%b",
                     bridge_en, owner, sb_want, sb_exp);
          end
        end
      end
      prev_en = bridge_en;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic s_cl, input logic s_da);
    if (p == 0) begin
      scl0 = s_cl;
      sda0 = s_da;
    end else begin
      scl1 = s_cl;
      sda1 = s_da;
    end
  endtask

  task automatic i2c_start(input int p);
    drive(p, 1'b1, 1'b0);
    tick(5);
    drive(p, 1'b0, 1'b0);
    tick(1);
  endtask

  task automatic i2c_byte(input int p, input logic [7:0] b);
    logic d;
    for (int i = 0; i < 9; i++) begin
      d = (i < 8) ? b[7-i] : 1'b1;
      drive(p, 1'b0, d);
      tick(2);
      drive(p, 1'b1, d);
      tick(4);
      drive(p, 1'b0, d);
      tick(2);
    end
  endtask

  task automatic i2c_stop(input int p);
    drive(p, 1'b0, 1'b0);
    tick(2);
    drive(p, 1'b1, 1'b0);
    tick(4);
    drive(p, 1'b1, 1'b1);
  endtask

  task automatic wait_grant(input int p);
    logic [1:0] want;
    int guard;
    want  = (p == 0) ? 2'b01 : 2'b10;
    guard = 0;
    @(negedge clk);
    while (bridge_en !== want && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bridge_en !== want) begin
      errors++;
      $display("FAIL grant_p%0d: bridge_en=%b, required %b", p, bridge_en, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic measure_replay(input int p, output int n_sda, output int n_both,
                                output int hold_bad);
    int guard;
    guard = 0; n_sda = 0; n_both = 0; hold_bad = 0;
    @(negedge clk);
    while (!sda_dn_low && guard < 40) begin @(negedge clk); guard++; end
    while (sda_dn_low && !scl_dn_low && guard < 200) begin
      n_sda++;
      @(negedge clk);
      guard++;
    end
    while (sda_dn_low && scl_dn_low && guard < 200) begin
      n_both++;
      if (scl_hold[p] !== 1'b1) hold_bad++;
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic measure_free(output int n);
    int guard;
    guard = 0;
    n     = 0;
    @(negedge clk);
    while (bridge_en !== 2'b00 && guard < 100) begin @(negedge clk); guard++; end
    while (busy === 1'b1 && guard < 200) begin
      n++;
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    @(negedge clk);
    checks++; if (bridge_en !== 2'b00) begin errors++; $display("FAIL reset_bridge_en: got %b, required 00", bridge_en); end
    checks++; if (scl_hold !== 2'b00) begin errors++; $display("FAIL reset_scl_hold: got %b, required 00", scl_hold); end
    checks++; if (scl_dn_low !== 1'b0) begin errors++; $display("FAIL reset_scl_dn_low: got %b, required 0", scl_dn_low); end
    checks++; if (sda_dn_low !== 1'b0) begin errors++; $display("FAIL reset_sda_dn_low: got %b, required 0", sda_dn_low); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b, required 0", owner); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b, required 0", timeout); end
    reset = 1'b0;
    tick(4);
  endtask

  task automatic test_single();
    int n_sda, n_both, hold_bad, n_free;
    exp_q.push_back(1'b0);
    fork
      begin
        drive(0, 1'b1, 1'b0);
        tick(5);
        drive(0, 1'b0, 1'b0);
      end
      measure_replay(0, n_sda, n_both, hold_bad);
    join
    checks++; if (n_sda != 16) begin errors++; $display("FAIL single_sda_replay: %0d cycles, required 16", n_sda); end
    checks++; if (n_both != 16) begin errors++; $display("FAIL single_scl_replay: %0d cycles, required 16", n_both); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL single_scl_hold: %0d cycles unheld, required 0", hold_bad); end
    checks++; if (bridge_en !== 2'b01) begin errors++; $display("FAIL single_grant: bridge_en=%b, required 01", bridge_en); end
    checks++;
    if ({scl_dn_low, sda_dn_low, scl_hold} !== 4'b0000) begin
      errors++;
      $display("FAIL single_release: scl_dn=%b sda_dn=%b hold=%b, required all 0",
               scl_dn_low, sda_dn_low, scl_hold);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, required 1", busy); end
    tick(1);
    i2c_byte(0, 8'hA5);
    i2c_stop(0);
    measure_free(n_free);
    checks++; if (n_free != 16) begin errors++; $display("FAIL single_bus_free: %0d cycles, required 16", n_free); end
  endtask

  task automatic test_contention();
    int gap, hold_bad, guard, n_free;
    exp_q.push_back(1'b0);
    i2c_start(0);
    wait_grant(0);
    exp_q.push_back(1'b1);
    i2c_start(1);
    tick(4);
    @(negedge clk);
    checks++; if (scl_hold !== 2'b10) begin errors++; $display("FAIL contend_hold: scl_hold=%b, required 10", scl_hold); end
    @(posedge clk);
    #1;
    i2c_byte(0, 8'h3C);
    i2c_stop(0);
    gap = 0; hold_bad = 0; guard = 0;
    @(negedge clk);
    while (bridge_en !== 2'b10 && guard < 300) begin
      if (bridge_en === 2'b00) gap++;
      if (scl_hold[1] !== 1'b1) hold_bad++;
      guard++;
      @(negedge clk);
    end
    checks++; if (gap != 49) begin errors++; $display("FAIL contend_gap: %0d cycles, required 49", gap); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL contend_hold_span: %0d cycles unheld, required 0", hold_bad); end
    checks++; if (scl_hold !== 2'b00) begin errors++; $display("FAIL contend_release: scl_hold=%b, required 00", scl_hold); end
    @(posedge clk);
    #1;
    i2c_stop(1);
    measure_free(n_free);
    checks++; if (n_free != 16) begin errors++; $display("FAIL contend_bus_free: %0d cycles, required 16", n_free); end
  endtask

  task automatic test_simultaneous();
    int n_free;
    do_reset();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    sda0 = 1'b0;
    sda1 = 1'b0;
    tick(5);
    scl0 = 1'b0;
    scl1 = 1'b0;
    tick(1);
    wait_grant(1);
    @(negedge clk);
    checks++; if (scl_hold !== 2'b01) begin errors++; $display("FAIL simul_hold: scl_hold=%b, required 01", scl_hold); end
    @(posedge clk);
    #1;
    i2c_stop(1);
    wait_grant(0);
    i2c_stop(0);
    measure_free(n_free);
    checks++; if (n_free != 16) begin errors++; $display("FAIL simul_bus_free: %0d cycles, required 16", n_free); end
  endtask

  task automatic test_timeout();
    int n_on, n_free, guard;
    exp_q.push_back(1'b1);
    drive(1, 1'b1, 1'b0);
    guard = 0;
    @(negedge clk);
    while (bridge_en !== 2'b10 && guard < 100) begin @(negedge clk); guard++; end
    n_on = 0;
    while (bridge_en === 2'b10 && n_on < 300) begin n_on++; @(negedge clk); end
    checks++; if (n_on != 100) begin errors++; $display("FAIL timeout_span: grant held %0d cycles, required 100", n_on); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b, required 1", timeout); end
    checks++;
    if (bridge_en !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_revoke: bridge_en=%b busy=%b, required 00/1", bridge_en, busy);
    end
    n_free = 1;
    @(negedge clk);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_width: got %b one cycle later, required 0", timeout); end
    while (busy === 1'b1 && n_free < 100) begin n_free++; @(negedge clk); end
    checks++; if (n_free != 16) begin errors++; $display("FAIL timeout_bus_free: %0d cycles, required 16", n_free); end
    @(posedge clk);
    #1;
    drive(1, 1'b1, 1'b1);
    tick(8);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bridge_en !== 2'b00) begin
      errors++;
      $display("FAIL timeout_late_stop: busy=%b bridge_en=%b, required 0/00", busy, bridge_en);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stop_start();
    int gap, guard, n_free;
    exp_q.push_back(1'b0);
    i2c_start(0);
    wait_grant(0);
    i2c_byte(0, 8'h5A);
    drive(0, 1'b0, 1'b0);
    tick(2);
    drive(0, 1'b1, 1'b0);
    tick(4);
    exp_q.push_back(1'b1);
    sda0 = 1'b1;
    sda1 = 1'b0;
    guard = 0;
    @(negedge clk);
    while (bridge_en !== 2'b00 && guard < 20) begin @(negedge clk); guard++; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stopstart_free: busy=%b, required 1", busy); end
    gap = 0; guard = 0;
    while (bridge_en !== 2'b10 && guard < 300) begin
      if (bridge_en === 2'b00) gap++;
      guard++;
      @(negedge clk);
    end
    checks++; if (gap != 49) begin errors++; $display("FAIL stopstart_gap: %0d cycles, required 49", gap); end
    @(posedge clk);
    #1;
    sda1 = 1'b1;
    measure_free(n_free);
    checks++; if (n_free != 16) begin errors++; $display("FAIL stopstart_bus_free: %0d cycles, required 16", n_free); end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    fork
      begin
        drive(1, 1'b1, 1'b0);
        tick(5);
        drive(1, 1'b0, 1'b0);
      end
      begin
        @(negedge clk);
        while (scl_dn_low !== 1'b1 && guard < 80) begin @(negedge clk); guard++; end
      end
    join
    checks++; if (scl_dn_low !== 1'b1) begin errors++; $display("FAIL resetmid_replay: scl_dn_low=%b, required 1", scl_dn_low); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bridge_en, scl_hold, scl_dn_low, sda_dn_low, owner, busy, timeout} !== 9'b0) begin
      errors++;
      $display("FAIL resetmid_outputs: en=%b hold=%b scl_dn=%b sda_dn=%b owner=%b busy=%b to=%b, required all 0",
               bridge_en, scl_hold, scl_dn_low, sda_dn_low, owner, busy, timeout);
    end
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b1);
    tick(2);
    drive(1, 1'b1, 1'b1);
    tick(8);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL resetmid_idle: busy=%b, required 0", busy); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    scl0  = 1'b1;
    sda0  = 1'b1;
    scl1  = 1'b1;
    sda1  = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_simultaneous();
    test_timeout();
    test_stop_start();
    test_reset_mid();
    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d grants outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: time limit reached before summary, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_bridge_arbiter.md
Name: i2c_bridge_arbiter

Overview:
- Shares one downstream I2C segment between two upstream I2C master ports, each connected through its own i2c_bridge instance.
- Watches START/STOP on both upstream ports and grants the downstream segment to one master per transaction by enabling that master's bridge.
- Holds a losing master's SCL low until its turn, then replays its START condition downstream.
- Includes a stuck-bus timeout so a hung owner cannot hold the segment forever.

Parameters:
- BUS_FREE_CYCLES, 16: idle clk cycles required after a STOP before the next grant.
- START_HOLD_CYCLES, 16: clk cycles for each phase of the replayed START (SDA-low hold, then SCL-low hold).
- TIMEOUT_CYCLES, 65535: clk cycles with no SCL edge from the owner before the grant is forcibly revoked.
- CNT_W, 16: counter width; must satisfy 2**CNT_W > max(all cycle parameters).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- scl_m0_in  input  1  raw SCL level at master port 0
- sda_m0_in  input  1  raw SDA level at master port 0
- scl_m1_in  input  1  raw SCL level at master port 1
- sda_m1_in  input  1  raw SDA level at master port 1
- bridge_en  output  2  enable to bridge instance n (one-hot or zero)
- scl_hold  output  2  1 = drive master port n SCL low (clock stretch)
- scl_dn_low  output  1  1 = drive downstream SCL low (replay)
- sda_dn_low  output  1  1 = drive downstream SDA low (replay)
- owner  output  1  index of the current or last grantee
- busy  output  1  downstream segment allocated
- timeout  output  1  one-cycle pulse when the timeout fires

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; pending flags 0; owner 0.
- Input conditioning:
  - Every *_in passes through a 2-flop synchroniser, then one more register for edge detection.
  - Events are seen 3 cycles after the pin changes.
- Edge events per port:
  - START = synchronised SDA falls while SCL is 1.
  - STOP = synchronised SDA rises while SCL is 1.
- Pending flags:
  - pend[n] sets on a START at port n when n is not the owner in GRANT.
  - pend[n] clears when n is granted.
  - While pend[n]=1 and synchronised scl_mn=0: scl_hold[n]=1. The master has pulled SCL low after its START, and the hold then freezes it.
- States:
  - IDLE: busy=0. If any pend is set, pick a winner and go to REPLAY_SDA.
    - One pending: that one wins.
    - Both pending: the port that is not owner wins (round-robin).
    - Load owner, load counter.
  - REPLAY_SDA: sda_dn_low=1 for START_HOLD_CYCLES, then go to REPLAY_SCL.
  - REPLAY_SCL: sda_dn_low=1 and scl_dn_low=1 for START_HOLD_CYCLES, then go to GRANT.
  - GRANT:
    - bridge_en[owner]=1; pend[owner] clears.
    - scl_hold[owner] and scl_dn_low/sda_dn_low release in the same cycle that bridge_en asserts.
    - Counter reloads on every owner SCL edge.
    - Owner STOP, or counter reaching 0: go to FREE. A counter expiry also pulses timeout.
  - FREE: bridge_en=0, busy=1, counter = BUS_FREE_CYCLES. Any owner START restarts the count. At 0, go to IDLE.
- Direct grant: a START at a port while in IDLE with no pending is handled through the same pend path. START is always replayed, so downstream sees exactly one START per transaction.
- Repeated START from the owner in GRANT: no action; it passes through the bridge.
- Simultaneous STOP from the owner and START from the other port in the same cycle: the STOP is honoured and the other port's pend is set.
- Timeout revokes the grant: bridge_en drops and the owner's SDA/SCL are no longer forwarded. If the timed-out master later issues a STOP, it is ignored. Its next START sets pend as normal.
- Reset mid-operation: all drives release in the cycle after reset is sampled, and state returns to IDLE. The downstream segment may be left mid-transfer; recovery is software's job.
- Counter: CNT_W bits, decrements to 0 and holds; no wrap.

Decomposition:
- Shared package i2c_pkg:
  - State encoding: IDLE, REPLAY_SDA, REPLAY_SCL, GRANT, FREE.
  - Event struct {start, stop, scl_edge}.
  - Port-count constant NUM_MASTERS=2.
- One sub-module: i2c_bus_monitor.
  - Does the synchroniser, edge registers and start/stop/scl_edge outputs.
  - Instantiated once per master port.

Test Plan:
- Single master: port 0 issues START, 1 byte, STOP.
  - Replay visible downstream: SDA low 16 cycles, then SCL low 16 cycles.
  - bridge_en=01 after 32 cycles; busy drops 16 cycles after STOP.
- Contention: port 1 STARTs while port 0 in GRANT.
  - scl_hold[1]=1 until port 0 STOP + 16 idle cycles.
  - Port 1 START replayed; bridge_en goes to 10.
- Simultaneous START on both ports from reset (owner=0): port 1 granted first, port 0 second.
- Timeout: TIMEOUT_CYCLES=100; owner freezes SCL high after START.
  - timeout pulses at cycle 100; bridge_en=00; FREE, then IDLE.
- STOP and the other port's START in the same cycle: FREE entered, pend set, other port granted after BUS_FREE_CYCLES.
- Reset asserted during REPLAY_SCL: next cycle all outputs 0, state IDLE.
